// File: rtl/hl_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hl_match_ctrl
// Purpose  : Match controller for a two-player higher/lower guessing game.
//            Sequences turns between two players, forwards one accepted
//            guess per turn to the game datapath, scores the judged outcome,
//            enforces a per-turn time limit and declares the match winner.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ROUNDS        turns per player per match (1..15)
//   TIMEOUT       cycles allowed per turn (fits a 26-bit counter)
// Ports
//   clk           clock, rising edge
//   reset         asynchronous, active-high reset
//   start         level button, rising edge starts a match (IDLE/DONE only)
//   p1_higher/p1_lower/p2_higher/p2_lower
//                 player guess buttons (levels, edge detected internally)
//   result_valid  one-cycle pulse from the datapath: a guess was judged
//   result_win    guess outcome, qualified by result_valid
//   btn_higher/btn_lower
//                 one-cycle guess pulses to the datapath
//   game_restart  one-cycle pulse re-arming the datapath at each turn
//   active_player 0 = player 1, 1 = player 2
//   score_p1/score_p2  wins per player (saturating at 15)
//   round         current round, 1-based while playing
//   match_over    high while the match result is displayed
//   winner        01 = P1, 10 = P2, 11 = tie, 00 = none
// ============================================================================
module hl_match_ctrl #(
    parameter int ROUNDS  = 5,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_higher,
    input  logic       p1_lower,
    input  logic       p2_higher,
    input  logic       p2_lower,
    input  logic       result_valid,
    input  logic       result_win,
    output logic       btn_higher,
    output logic       btn_lower,
    output logic       game_restart,
    output logic       active_player,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [3:0] round,
    output logic       match_over,
    output logic [1:0] winner
);

    localparam int              c_cnt_w     = 26;
    localparam logic [25:0]     c_turn_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [3:0]      c_rounds    = 4'(ROUNDS);

    // Bit positions inside the sampled button vector
    localparam int c_b_p2l   = 0;
    localparam int c_b_p2h   = 1;
    localparam int c_b_p1l   = 2;
    localparam int c_b_p1h   = 3;
    localparam int c_b_start = 4;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ARM         = 3'd1,
        S_WAIT_GUESS  = 3'd2,
        S_WAIT_RESULT = 3'd3,
        S_NEXT        = 3'd4,
        S_DONE        = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_turn_cnt;

    // ------------------------------------------------------------------
    // Button sampling and rising-edge detection
    // ------------------------------------------------------------------
    logic [4:0] w_btn_in;
    logic [4:0] r_btn_smp;
    logic [4:0] r_btn_prev;
    logic       r_primed;
    logic [4:0] w_edge;

    assign w_btn_in = {start, p1_higher, p1_lower, p2_higher, p2_lower};

    // On the first clock after reset the history is loaded with the live
    // input level, so a button held through reset cannot look like a fresh
    // press; it has to be released and pressed again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_smp  <= '0;
            r_btn_prev <= '0;
            r_primed   <= 1'b0;
        end else begin
            r_btn_smp  <= w_btn_in;
            r_btn_prev <= r_primed ? r_btn_smp : w_btn_in;
            r_primed   <= 1'b1;
        end
    end

    assign w_edge = r_btn_smp & ~r_btn_prev;

    // Only the active player's buttons are considered
    logic w_start_edge;
    logic w_hi_edge;
    logic w_lo_edge;

    assign w_start_edge = w_edge[c_b_start];
    assign w_hi_edge    = active_player ? w_edge[c_b_p2h] : w_edge[c_b_p1h];
    assign w_lo_edge    = active_player ? w_edge[c_b_p2l] : w_edge[c_b_p1l];

    // Turn ends on the cycle the counter reaches its last value
    logic w_turn_expired;
    assign w_turn_expired = (r_turn_cnt >= c_turn_last);

    // Final verdict from the current scores, captured on entry to DONE
    logic [1:0] w_verdict;
    always_comb begin
        w_verdict = 2'b11;
        if (score_p1 > score_p2) begin
            w_verdict = 2'b01;
        end else if (score_p2 > score_p1) begin
            w_verdict = 2'b10;
        end
    end

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    // ------------------------------------------------------------------
    // Match FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_turn_cnt    <= '0;
            btn_higher    <= 1'b0;
            btn_lower     <= 1'b0;
            game_restart  <= 1'b0;
            active_player <= 1'b0;
            score_p1      <= 4'd0;
            score_p2      <= 4'd0;
            round         <= 4'd0;
            match_over    <= 1'b0;
            winner        <= 2'b00;
        end else begin
            // Pulse outputs default low so they last exactly one cycle
            btn_higher   <= 1'b0;
            btn_lower    <= 1'b0;
            game_restart <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_edge) begin
                        score_p1      <= 4'd0;
                        score_p2      <= 4'd0;
                        round         <= 4'd1;
                        active_player <= 1'b0;
                        match_over    <= 1'b0;
                        winner        <= 2'b00;
                        r_state       <= S_ARM;
                    end
                end

                S_ARM: begin
                    game_restart <= 1'b1;
                    r_turn_cnt   <= '0;
                    r_state      <= S_WAIT_GUESS;
                end

                S_WAIT_GUESS: begin
                    // Exactly one of higher/lower must have an edge; both
                    // at once is ambiguous and is dropped.
                    if (w_hi_edge ^ w_lo_edge) begin
                        btn_higher <= w_hi_edge;
                        btn_lower  <= w_lo_edge;
                        r_turn_cnt <= r_turn_cnt + 1'b1;
                        r_state    <= S_WAIT_RESULT;
                    end else if (w_turn_expired) begin
                        r_state    <= S_NEXT;
                    end else begin
                        r_turn_cnt <= r_turn_cnt + 1'b1;
                    end
                end

                S_WAIT_RESULT: begin
                    if (result_valid) begin
                        if (result_win) begin
                            if (active_player) begin
                                score_p2 <= sat_inc(score_p2);
                            end else begin
                                score_p1 <= sat_inc(score_p1);
                            end
                        end
                        r_state <= S_NEXT;
                    end else if (w_turn_expired) begin
                        // No verdict in time: the turn counts as a loss
                        r_state <= S_NEXT;
                    end else begin
                        r_turn_cnt <= r_turn_cnt + 1'b1;
                    end
                end

                S_NEXT: begin
                    if (active_player && (round == c_rounds)) begin
                        match_over <= 1'b1;
                        winner     <= w_verdict;
                        r_state    <= S_DONE;
                    end else begin
                        if (active_player) begin
                            round <= round + 4'd1;
                        end
                        active_player <= ~active_player;
                        r_state       <= S_ARM;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
